// File: rtl/prio_event_encoder_pkg.sv
// Shared constants and sizing helper for the priority event encoder.
package prio_pkg;

  // Arbitration policy selectors for RR_MODE.
  localparam int PRIO_FIXED = 0;
  localparam int PRIO_RR    = 1;

  // Index width for n channels (ceil(log2(n)), minimum 1 for n >= 2).
  function automatic int prio_idxw(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/prio_event_encoder_pick.sv
// Combinational highest-set-bit finder used by the event encoder.
module prio_pick
  import prio_pkg::*;
#(
  parameter  int N    = 8,
  localparam int IDXW = prio_idxw(N)
) (
  input  logic [N-1:0]    vec,
  output logic            any,
  output logic [IDXW-1:0] idx
);

  // Ascending scan; the last set bit seen is the highest index.
  always_comb begin
    any = |vec;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        idx = IDXW'(i);
      end
    end
  end

endmodule

// File: rtl/prio_event_encoder.sv
// Registered priority event encoder: sticky pending bits, optional mask,
// fixed-priority or round-robin winner selection, valid/ready output.
module prio_event_encoder
  import prio_pkg::*;
#(
  parameter  int N       = 8,
  parameter  int RR_MODE = PRIO_FIXED,
  localparam int IDXW    = prio_idxw(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    mask,
  input  logic            clr_all,
  output logic            out_valid,
  output logic [IDXW-1:0] out_idx,
  input  logic            out_ready,
  output logic [N-1:0]    pending_o
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PRESENT = 1'b1;

  // N expressed in the index-plus-carry width used for the modulo wrap.
  localparam logic [IDXW:0] N_W = (IDXW + 1)'(N);

  logic [N-1:0]    pending_q, pending_d;
  logic [0:0]      state_q, state_d;
  logic            out_valid_q, out_valid_d;
  logic [IDXW-1:0] out_idx_q, out_idx_d;
  logic [IDXW-1:0] last_grant_q, last_grant_d;

  logic [N-1:0]    eligible;
  logic [2*N-1:0]  elig_dbl;
  logic [IDXW-1:0] rot_base;
  logic [N-1:0]    pick_vec;
  logic            pick_any;
  logic [IDXW-1:0] pick_idx;
  logic [IDXW:0]   idx_sum;
  logic [IDXW-1:0] winner;
  logic            handshake;
  logic [N-1:0]    clr_bit;

  // Rotate eligible so the channel just below last_grant lands on the top
  // bit; in fixed mode the rotation is zero and the pick is plain priority.
  always_comb begin
    eligible = pending_q & ~mask;
    elig_dbl = {eligible, eligible};
    rot_base = (RR_MODE == PRIO_RR) ? last_grant_q : '0;
    pick_vec = elig_dbl[rot_base +: N];
  end

  prio_pick #(.N(N)) u_pick (
    .vec (pick_vec),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Undo the rotation: winner = (pick_idx + rot_base) mod N.
  always_comb begin
    idx_sum = {1'b0, pick_idx} + {1'b0, rot_base};
    winner  = (idx_sum >= N_W) ? IDXW'(idx_sum - N_W) : IDXW'(idx_sum);
  end

  // Next-state logic: pending update, 2-state FSM and output registers.
  always_comb begin
    handshake    = (state_q == ST_PRESENT) && out_ready;
    clr_bit      = handshake ? (N'(1) << out_idx_q) : '0;
    // A new request on the accepted channel survives the clear.
    pending_d    = (pending_q & ~clr_bit) | req;
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    out_idx_d    = out_idx_q;
    last_grant_d = last_grant_q;

    if (clr_all) begin
      pending_d   = '0;
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
    end else if (state_q == ST_IDLE) begin
      if (pick_any) begin
        out_idx_d   = winner;
        out_valid_d = 1'b1;
        state_d     = ST_PRESENT;
      end
    end else begin
      // Presented winner is held until accepted, regardless of mask/req.
      if (out_ready) begin
        last_grant_d = out_idx_q;
        out_valid_d  = 1'b0;
        state_d      = ST_IDLE;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q    <= '0;
      state_q      <= ST_IDLE;
      out_valid_q  <= 1'b0;
      out_idx_q    <= '0;
      last_grant_q <= '0;
    end else begin
      pending_q    <= pending_d;
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_idx_q    <= out_idx_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign pending_o = pending_q;

endmodule
